// File: rtl/hack_mem_pkg.sv
// Shared types for the HACK data RAM arbiter: bus widths, requester
// ownership encoding and the read-return tag carried down the latency pipe.
package hack_mem_pkg;

   localparam int unsigned ADDR_W = 15;
   localparam int unsigned DATA_W = 16;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_VID = 1'b1
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } rd_tag_t;

   localparam rd_tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_CPU};

endpackage

// File: rtl/hack_ram_arbiter_if.sv
// Bundle of the CPU port, video port and RAM macro signals around the arbiter.
// slave = arbiter view, master = surrounding CPU/screen/RAM view.
interface hack_ram_arbiter_if;
   import hack_mem_pkg::*;

   logic              cpu_req;
   logic              cpu_load;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_in;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_out;

   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic              vid_gnt;
   logic              vid_rvalid;
   logic [DATA_W-1:0] vid_out;

   logic [ADDR_W-1:0] ram_addr;
   logic              ram_load;
   logic [DATA_W-1:0] ram_in;
   logic [DATA_W-1:0] ram_out;

   modport slave (
      input  cpu_req, cpu_load, cpu_addr, cpu_in,
      output cpu_gnt, cpu_rvalid, cpu_out,
      input  vid_req, vid_addr,
      output vid_gnt, vid_rvalid, vid_out,
      output ram_addr, ram_load, ram_in,
      input  ram_out
   );

   modport master (
      output cpu_req, cpu_load, cpu_addr, cpu_in,
      input  cpu_gnt, cpu_rvalid, cpu_out,
      output vid_req, vid_addr,
      input  vid_gnt, vid_rvalid, vid_out,
      input  ram_addr, ram_load, ram_in,
      output ram_out
   );

endinterface

// File: rtl/hack_ram_arbiter_tag_pipe.sv
// Read-return tag shift register; its tail lines up with the RAM read data
// DEPTH cycles after the access was issued.
module hack_rd_tag_pipe
   import hack_mem_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic    clk,
   input  logic    reset,
   input  rd_tag_t tag_i,
   output rd_tag_t tag_o
);

   rd_tag_t stage_q [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_q[i] <= TAG_NONE;
         end
      end else begin
         stage_q[0] <= tag_i;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/hack_ram_arbiter.sv
// Single-port HACK data RAM arbiter: CPU priority with a video starvation
// guard, one access per cycle, tagged in-order read return.
module hack_ram_arbiter
   import hack_mem_pkg::*;
#(
   parameter int unsigned RD_LAT       = 1,
   parameter int unsigned VID_MAX_WAIT = 4
) (
   input  logic               clk,
   input  logic               reset,
   hack_ram_arbiter_if.slave  bus
);

   localparam logic [3:0] WAIT_MAX = 4'(VID_MAX_WAIT);

   logic [3:0]        wait_cnt_q, wait_cnt_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] cpu_out_q, vid_out_q;
   logic              force_vid, cpu_gnt, vid_gnt;
   logic              cpu_rvalid, vid_rvalid;
   rd_tag_t           tag_in, tag_tail;

   always_comb begin
      force_vid = !reset && bus.vid_req && (wait_cnt_q == WAIT_MAX);
      cpu_gnt   = !reset && bus.cpu_req && !force_vid;
      vid_gnt   = !reset && bus.vid_req && (force_vid || !bus.cpu_req);

      // With no grant the address bus parks on the last issued address.
      ram_addr_d = ram_addr_q;
      if (cpu_gnt) begin
         ram_addr_d = bus.cpu_addr;
      end else if (vid_gnt) begin
         ram_addr_d = bus.vid_addr;
      end

      wait_cnt_d = wait_cnt_q;
      if (!bus.vid_req || vid_gnt) begin
         wait_cnt_d = 4'd0;
      end else if (wait_cnt_q < WAIT_MAX) begin
         wait_cnt_d = wait_cnt_q + 4'd1;
      end

      tag_in = TAG_NONE;
      if (cpu_gnt && !bus.cpu_load) begin
         tag_in = '{valid: 1'b1, owner: OWN_CPU};
      end else if (vid_gnt) begin
         tag_in = '{valid: 1'b1, owner: OWN_VID};
      end

      cpu_rvalid = !reset && tag_tail.valid && (tag_tail.owner == OWN_CPU);
      vid_rvalid = !reset && tag_tail.valid && (tag_tail.owner == OWN_VID);
   end

   hack_rd_tag_pipe #(
      .DEPTH (RD_LAT)
   ) u_tag_pipe (
      .clk   (clk),
      .reset (reset),
      .tag_i (tag_in),
      .tag_o (tag_tail)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_q <= 4'd0;
         ram_addr_q <= '0;
         cpu_out_q  <= '0;
         vid_out_q  <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         ram_addr_q <= ram_addr_d;
         if (cpu_rvalid) cpu_out_q <= bus.ram_out;
         if (vid_rvalid) vid_out_q <= bus.ram_out;
      end
   end

   assign bus.cpu_gnt    = cpu_gnt;
   assign bus.vid_gnt    = vid_gnt;
   assign bus.ram_addr   = reset ? '0 : ram_addr_d;
   assign bus.ram_load   = cpu_gnt && bus.cpu_load;
   assign bus.ram_in     = cpu_gnt ? bus.cpu_in : '0;
   assign bus.cpu_rvalid = cpu_rvalid;
   assign bus.vid_rvalid = vid_rvalid;
   // Read data is presented in the rvalid cycle itself, then held.
   assign bus.cpu_out    = cpu_rvalid ? bus.ram_out : cpu_out_q;
   assign bus.vid_out    = vid_rvalid ? bus.ram_out : vid_out_q;

endmodule

// File: tb/tb_hack_ram_arbiter.sv
// Randomized bench for hack_ram_arbiter against a transaction-level model
// (shadow memory + response queue) with a write-first DFF RAM stub.
module tb_hack_ram_arbiter;
   import hack_mem_pkg::*;

   localparam int RD_LAT = 3;
   localparam int MAXW   = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hack_ram_arbiter_if bus ();

   hack_ram_arbiter #(
      .RD_LAT       (RD_LAT),
      .VID_MAX_WAIT (MAXW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // RAM stub: synchronous write-first read, RD_LAT register stages
   logic [15:0] mem [0:32767];
   logic [15:0] rd_pipe [RD_LAT];
   always @(posedge clk) begin
      if (bus.ram_load) mem[bus.ram_addr] <= bus.ram_in;
      rd_pipe[0] <= bus.ram_load ? bus.ram_in : mem[bus.ram_addr];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.ram_out = rd_pipe[RD_LAT-1];

   // reference model
   typedef struct {
      int          due;
      bit          own_vid;
      logic [15:0] data;
   } resp_t;

   logic [15:0] shadow [0:32767];
   resp_t       rq [$];
   int          cyc = 0;
   int          denied = 0;
   logic [14:0] last_addr = '0;
   logic [15:0] exp_cpu_out = '0;
   logic [15:0] exp_vid_out = '0;
   bit          got_c, got_v;
   int          n_chk = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step();
      bit          egc, egv, ecrv, evrv, frc;
      logic [14:0] eaddr;
      resp_t       r;
      @(negedge clk);
      egc = 0; egv = 0; ecrv = 0; evrv = 0;
      if (!reset) begin
         frc = bus.vid_req && (denied == MAXW);
         if (frc)               egv = 1;
         else if (bus.cpu_req)  egc = 1;
         else if (bus.vid_req)  egv = 1;
         if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            if (r.own_vid) begin evrv = 1; exp_vid_out = r.data; end
            else           begin ecrv = 1; exp_cpu_out = r.data; end
         end
      end
      eaddr = reset ? 15'd0 : egc ? bus.cpu_addr : egv ? bus.vid_addr : last_addr;

      chk("cpu_gnt",    32'(bus.cpu_gnt),    32'(egc));
      chk("vid_gnt",    32'(bus.vid_gnt),    32'(egv));
      chk("ram_load",   32'(bus.ram_load),   32'(egc && bus.cpu_load));
      chk("ram_addr",   32'(bus.ram_addr),   32'(eaddr));
      chk("ram_in",     32'(bus.ram_in),     egc ? 32'(bus.cpu_in) : 32'd0);
      chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(ecrv));
      chk("vid_rvalid", 32'(bus.vid_rvalid), 32'(evrv));
      chk("cpu_out",    32'(bus.cpu_out),    32'(exp_cpu_out));
      chk("vid_out",    32'(bus.vid_out),    32'(exp_vid_out));
      chk("wait_cnt",   32'(dut.wait_cnt_q), 32'(denied));

      if (reset) begin
         rq.delete();
         denied = 0; last_addr = '0; exp_cpu_out = '0; exp_vid_out = '0;
      end else begin
         if (egc) begin
            if (bus.cpu_load) shadow[bus.cpu_addr] = bus.cpu_in;
            else rq.push_back('{due: cyc + RD_LAT, own_vid: 1'b0, data: shadow[bus.cpu_addr]});
         end
         if (egv) rq.push_back('{due: cyc + RD_LAT, own_vid: 1'b1, data: shadow[bus.vid_addr]});
         if (egc || egv) last_addr = eaddr;
         if (!bus.vid_req || egv) denied = 0;
         else if (denied < MAXW) denied++;
      end
      got_c = egc; got_v = egv;
      cyc++;
      @(posedge clk); #1;
   endtask

   task automatic cpu_set(input bit req, input bit load, input logic [14:0] a, input logic [15:0] d);
      bus.cpu_req = req; bus.cpu_load = load; bus.cpu_addr = a; bus.cpu_in = d;
   endtask

   function automatic logic [14:0] pick_addr();
      logic [14:0] a;
      a = 15'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) a = a | 15'h4000;
      return a;
   endfunction

   initial begin
      logic [15:0] v;
      for (int i = 0; i < 32768; i++) begin
         v = 16'($urandom);
         mem[i] <= v;
         shadow[i] = v;
      end
      reset = 1'b1;
      cpu_set(0, 0, '0, '0);
      bus.vid_req = 1'b0; bus.vid_addr = '0;
      @(posedge clk); #1;
      step();
      reset = 1'b0;
      repeat (3) step();

      // CPU write then read-back of the same word
      cpu_set(1, 1, 15'h0010, 16'h1234); step();
      cpu_set(1, 0, 15'h0010, 16'h0000); step();
      cpu_set(0, 0, 15'h0000, 16'h0000);
      repeat (RD_LAT + 1) step();

      // both requesting continuously: starvation guard kicks in
      cpu_set(1, 0, 15'h0003, 16'h0); bus.vid_req = 1'b1; bus.vid_addr = 15'h4001;
      repeat (12) step();
      cpu_set(0, 0, '0, '0); bus.vid_req = 1'b0;
      repeat (RD_LAT + 1) step();

      // alternating owners on consecutive cycles
      cpu_set(1, 0, 15'h0001, 16'h0); step();
      cpu_set(0, 0, 15'h0000, 16'h0); bus.vid_req = 1'b1; bus.vid_addr = 15'h4000; step();
      cpu_set(1, 0, 15'h0002, 16'h0); bus.vid_req = 1'b0; step();
      cpu_set(0, 0, '0, '0);
      repeat (RD_LAT + 1) step();

      // reset the cycle after a CPU read is granted
      cpu_set(1, 0, 15'h0005, 16'h0); step();
      cpu_set(0, 0, '0, '0); reset = 1'b1; step();
      reset = 1'b0;
      repeat (RD_LAT + 3) step();

      // video only
      bus.vid_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.vid_addr = 15'(15'h4000 + i);
         step();
      end
      bus.vid_req = 1'b0;
      repeat (RD_LAT + 1) step();

      // random traffic, requests held until granted, occasional drop/reset
      for (int n = 0; n < 800; n++) begin
         if (!bus.cpu_req || got_c) begin
            cpu_set($urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0, pick_addr(), 16'($urandom));
         end else if ($urandom_range(0, 19) == 0) begin
            bus.cpu_req = 1'b0;
         end
         if (!bus.vid_req || got_v) begin
            bus.vid_req  = $urandom_range(0, 9) < 5;
            bus.vid_addr = pick_addr();
         end else if ($urandom_range(0, 29) == 0) begin
            bus.vid_req = 1'b0;
         end
         reset = ($urandom_range(0, 79) == 0);
         step();
      end
      reset = 1'b0;
      cpu_set(0, 0, '0, '0); bus.vid_req = 1'b0;
      repeat (RD_LAT + 2) step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/hack_ram_arbiter.md
Name: hack_ram_arbiter

Overview:
Shares one single-port HACK data RAM between two requesters: the CPU data port and the screen scan-out reader. The RAM is built from DFF registers with synchronous read. Arbitration is CPU-priority, with a starvation guard for the video reader. At most one RAM access is issued per cycle. Read data returns through a latency pipeline tagged with the owning requester. The block sits between the CPU/screen logic and the RAM macro.

Parameters:
ADDR_W, 15, RAM address width (HACK 32K words)
DATA_W, 16, RAM word width
RD_LAT, 1, RAM read latency in cycles; legal range 1..4
VID_MAX_WAIT, 4, cycles video may be denied before it is forced to win; legal range 1..15

Ports:
clk  in  1  single system clock, all logic on rising edge
reset  in  1  synchronous, active-high
cpu_req  in  1  CPU access request; held with cpu_load/cpu_addr/cpu_in until cpu_gnt
cpu_load  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_in  in  DATA_W  CPU write data
cpu_gnt  out  1  combinational grant; access issued to RAM this cycle
cpu_rvalid  out  1  CPU read data valid
cpu_out  out  DATA_W  CPU read data
vid_req  in  1  video read request; held with vid_addr until vid_gnt
vid_addr  in  ADDR_W  video address
vid_gnt  out  1  combinational grant
vid_rvalid  out  1  video read data valid
vid_out  out  DATA_W  video read data
ram_addr  out  ADDR_W  RAM address
ram_load  out  1  RAM write enable
ram_in  out  DATA_W  RAM write data
ram_out  in  DATA_W  RAM read data, valid RD_LAT cycles after the read is issued

Behaviour:
- Reset values: cpu_gnt, vid_gnt, cpu_rvalid, vid_rvalid, ram_load = 0. ram_addr, ram_in, cpu_out, vid_out = 0. wait_cnt = 0. Tag pipeline cleared.
- Grant rule, evaluated combinationally each cycle:
  - force = vid_req && (wait_cnt == VID_MAX_WAIT).
  - If force, grant vid.
  - Otherwise, if cpu_req, grant cpu.
  - Otherwise, if vid_req, grant vid.
  - Otherwise, no grant.
  - cpu_gnt and vid_gnt are never both 1.
- RAM drive:
  - Granted requester's address drives ram_addr.
  - ram_load = cpu_gnt && cpu_load. The video requester never writes.
  - ram_in = cpu_in when CPU is granted; otherwise 0.
  - With no grant: ram_load = 0 and ram_addr is held at its last value.
- wait_cnt (4-bit register):
  - Increments when vid_req && !vid_gnt.
  - Clears on vid_gnt or !vid_req.
  - Saturates at VID_MAX_WAIT.
- Tag pipeline: RD_LAT-deep shift register of {valid, owner}.
  - Stage 0 loads {1, CPU} on a CPU read grant.
  - Stage 0 loads {1, VID} on a vid grant.
  - Stage 0 loads {0, x} on a write or no grant.
- Read return:
  - At the pipeline tail, the owner's rvalid pulses for exactly 1 cycle.
  - The owner's *_out captures ram_out on that cycle and holds it until the next rvalid for that owner.
  - Read latency from grant to rvalid is exactly RD_LAT cycles.
- Writes produce no response. Write completion is the grant cycle.
- Back-to-back: grants may issue every cycle. Responses return in issue order, one per cycle maximum.
- Read-after-write to the same address on consecutive cycles returns the new data. This follows from RAM write-first ordering; the arbiter adds no bypass.
- Request dropped before grant: legal. No state change except wait_cnt clearing.
- Reset mid-operation: in-flight responses are discarded and no rvalid follows. All state returns to reset values on the next edge.

Decomposition:
- Shared package hack_mem_pkg holds:
  - ADDR_W and DATA_W constants.
  - Owner encoding OWN_CPU = 1'b0, OWN_VID = 1'b1.
  - The tag struct {valid, owner}.
- One sub-module: hack_rd_tag_pipe, a parameterised RD_LAT-deep tag shift register with synchronous reset.
- Grant logic and wait_cnt stay in the top module.

Test Plan:
- Reset then idle: reset = 1 for 2 cycles, all req = 0 -> every output 0; ram_load never asserts.
- CPU write then read: cpu_load = 1, addr 0x0010, in 0x1234, then read 0x0010 -> ram_load = 1 on cycle 0; cpu_rvalid on cycle 1 + RD_LAT with cpu_out = 0x1234.
- Simultaneous requests: cpu_req and vid_req both held continuously, VID_MAX_WAIT = 4 -> grant pattern CPU×4, VID, CPU×4, VID; vid_rvalid RD_LAT after each vid grant.
- Alternating ownership, RD_LAT = 3: reads issued on consecutive cycles (CPU 0x0001, VID 0x4000, CPU 0x0002) -> rvalids in order on the matching ports, one per cycle, data matching the preloaded RAM.
- Reset mid-flight: CPU read granted, reset asserted the next cycle -> no cpu_rvalid ever; wait_cnt = 0 after reset.
- Video only: vid_req held for 8 cycles, no CPU -> vid_gnt every cycle, wait_cnt stays 0, 8 vid_rvalid pulses.
